// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI byte master
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SCK_HI,
      ST_SCK_LO,
      ST_FINISH
   } spi_state_e;

   localparam int SPI_BITS = 8;

   // Pin levels presented while idle or held in reset
   localparam logic CS_IDLE  = 1'b1;
   localparam logic SCK_IDLE = 1'b0;
   localparam logic SDI_IDLE = 1'b0;
   localparam logic [SPI_BITS-1:0] RX_RESET = '0;

endpackage

// File: rtl/spi_half_period_timer.sv
// rtl/spi_half_period_timer.sv - SCK half-period timer; tick on the CLK_DIV-th cycle after clear
module spi_half_period_timer #(
   parameter int CLK_DIV = 50
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = clear ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/spi_byte_master.sv
// rtl/spi_byte_master.sv - mode 0, MSB-first SPI master moving one byte per start
module spi_byte_master
   import spi_pkg::*;
#(
   parameter int CLK_DIV = 50
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       start,
   input  logic       cs_hold,
   input  logic       release_cs,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_data,
   output logic       spi_cs,
   output logic       spi_clk,
   output logic       spi_sdi,
   input  logic       spi_sdo
);

   spi_state_e          state_q, state_d;
   logic [SPI_BITS-1:0] shift_q, shift_d;
   logic [2:0]          bit_cnt_q, bit_cnt_d;
   logic                hold_q, hold_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [SPI_BITS-1:0] rx_q, rx_d;
   logic                cs_q, cs_d;
   logic                sck_q, sck_d;
   logic                sdi_q, sdi_d;
   logic                tick;
   logic                timer_clear;

   // Every tick outside IDLE causes a state change, so clearing on tick reloads the divider
   assign timer_clear = (state_q == ST_IDLE) || tick;

   spi_half_period_timer #(
      .CLK_DIV (CLK_DIV)
   ) u_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (timer_clear),
      .tick    (tick)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      hold_d    = hold_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      rx_d      = rx_q;
      cs_d      = cs_q;
      sck_d     = sck_q;
      sdi_d     = sdi_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               shift_d   = tx_data;
               hold_d    = cs_hold;
               bit_cnt_d = '0;
               busy_d    = 1'b1;
               cs_d      = 1'b0;
               sdi_d     = tx_data[7];
               state_d   = ST_SETUP;
            end else if (release_cs) begin
               cs_d = CS_IDLE;
            end
         end
         ST_SETUP, ST_SCK_LO: begin
            if (tick) begin
               sck_d   = 1'b1;
               state_d = ST_SCK_HI;
            end
         end
         ST_SCK_HI: begin
            if (tick) begin
               shift_d = {shift_q[SPI_BITS-2:0], spi_sdo};
               sck_d   = 1'b0;
               if (bit_cnt_q == 3'(SPI_BITS - 1)) begin
                  state_d = ST_FINISH;
               end else begin
                  // shift_q[6] becomes the MSB once this edge's shift lands
                  sdi_d     = shift_q[SPI_BITS-2];
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  state_d   = ST_SCK_LO;
               end
            end
         end
         ST_FINISH: begin
            if (tick) begin
               done_d  = 1'b1;
               rx_d    = shift_q;
               busy_d  = 1'b0;
               cs_d    = hold_q ? 1'b0 : CS_IDLE;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         hold_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rx_q      <= RX_RESET;
         cs_q      <= CS_IDLE;
         sck_q     <= SCK_IDLE;
         sdi_q     <= SDI_IDLE;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         hold_q    <= hold_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         rx_q      <= rx_d;
         cs_q      <= cs_d;
         sck_q     <= sck_d;
         sdi_q     <= sdi_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_data = rx_q;
   assign spi_cs  = cs_q;
   assign spi_clk = sck_q;
   assign spi_sdi = sdi_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// tb/tb_spi_byte_master.sv - directed bench for spi_byte_master at CLK_DIV 4 and 2
module tb_spi_byte_master;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   logic [7:0] tx4 = '0;
   logic       start4 = 1'b0, hold4 = 1'b0, rel4 = 1'b0;
   logic       busy4, done4, cs4, sck4, sdi4, sdo4;
   logic [7:0] rx4;

   logic [7:0] tx2 = '0;
   logic       start2 = 1'b0;
   logic       busy2, done2, cs2, sck2, sdi2, sdo2;
   logic [7:0] rx2;

   logic       loop4 = 1'b1;
   logic [7:0] dev_byte = '0;
   int         dev_idx = 0;
   logic       dev_prev_sck = 1'b0;
   logic [2:0] dev_sel;
   logic       dev_bit;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   spi_byte_master #(.CLK_DIV(4)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .tx_data(tx4), .start(start4), .cs_hold(hold4),
      .release_cs(rel4), .busy(busy4), .done(done4), .rx_data(rx4), .spi_cs(cs4),
      .spi_clk(sck4), .spi_sdi(sdi4), .spi_sdo(sdo4)
   );

   spi_byte_master #(.CLK_DIV(2)) u_dut2 (
      .clk(clk), .reset_n(reset_n), .tx_data(tx2), .start(start2), .cs_hold(1'b0),
      .release_cs(1'b0), .busy(busy2), .done(done2), .rx_data(rx2), .spi_cs(cs2),
      .spi_clk(sck2), .spi_sdi(sdi2), .spi_sdo(sdo2)
   );

   // Mode 0 slave: presents its MSB when selected, advances after each falling SCK
   always_comb begin
      dev_sel = 3'(7 - dev_idx);
      dev_bit = (dev_idx < 8) ? dev_byte[dev_sel] : 1'b0;
   end
   assign sdo4 = loop4 ? sdi4 : dev_bit;
   assign sdo2 = sdi2;

   always @(negedge clk) begin
      if (cs4) dev_idx <= 0;
      else if (dev_prev_sck && !sck4) dev_idx <= dev_idx + 1;
      dev_prev_sck <= sck4;
   end

   task automatic test_reset();
      checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b want 00", busy4, done4); end
      checks++; if (rx4 !== 8'h00) begin errors++; $display("FAIL reset_rx got %h want 00", rx4); end
      checks++; if ({cs4, sck4, sdi4} !== 3'b100) begin errors++; $display("FAIL reset_pins got cs/sck/sdi=%b want 100", {cs4, sck4, sdi4}); end
      checks++; if ({cs2, sck2, busy2} !== 3'b100) begin errors++; $display("FAIL reset_dut2 got cs/sck/busy=%b want 100", {cs2, sck2, busy2}); end
      @(negedge clk); reset_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if ({busy4, cs4, sck4} !== 3'b010) begin errors++; $display("FAIL idle_after_reset got busy/cs/sck=%b want 010", {busy4, cs4, sck4}); end
   endtask

   task automatic test_loopback();
      int cyc, rises, dones, done_cyc;
      logic prev, bad_rise, cs_at_done, busy_at_done;
      loop4 = 1'b1;
      @(negedge clk); tx4 = 8'hA5; hold4 = 1'b0; start4 = 1'b1;
      @(negedge clk); start4 = 1'b0; cyc = 1;
      checks++; if ({busy4, cs4, sdi4} !== 3'b101) begin errors++; $display("FAIL loop_cycle1 got busy/cs/sdi=%b want 101", {busy4, cs4, sdi4}); end
      rises = 0; dones = 0; done_cyc = 0; prev = sck4; bad_rise = 1'b0; cs_at_done = 1'b0; busy_at_done = 1'b1;
      while (cyc < 120) begin
         if (!prev && sck4) begin
            if (cyc != 1 + 4 * (2 * rises + 1)) bad_rise = 1'b1;
            rises++;
         end
         if (done4) begin dones++; done_cyc = cyc; cs_at_done = cs4; busy_at_done = busy4; end
         prev = sck4;
         @(negedge clk); cyc++;
      end
      checks++; if (rises != 8 || bad_rise) begin errors++; $display("FAIL loop_sck got rises=%0d misplaced=%b want 8 and 0", rises, bad_rise); end
      checks++; if (dones != 1 || done_cyc != 69) begin errors++; $display("FAIL loop_done got count=%0d cycle=%0d want 1 and 69", dones, done_cyc); end
      checks++; if (rx4 !== 8'hA5) begin errors++; $display("FAIL loop_rx got %h want a5", rx4); end
      checks++; if (cs_at_done !== 1'b1 || busy_at_done !== 1'b0) begin errors++; $display("FAIL loop_cs_busy_at_done got cs=%b busy=%b want 1 0", cs_at_done, busy_at_done); end
   endtask

   task automatic test_device();
      int cyc, rises;
      logic prev, prev_sdi, sdi_bad;
      logic [7:0] mosi;
      loop4 = 1'b0; dev_byte = 8'h3C;
      @(negedge clk); tx4 = 8'hC3; start4 = 1'b1;
      @(negedge clk); start4 = 1'b0; cyc = 1;
      rises = 0; mosi = '0; prev = sck4; prev_sdi = sdi4; sdi_bad = 1'b0;
      while (cyc < 100) begin
         if (!prev && sck4) begin mosi = {mosi[6:0], sdi4}; rises++; end
         if (sdi4 !== prev_sdi && sck4) sdi_bad = 1'b1;
         prev = sck4; prev_sdi = sdi4;
         @(negedge clk); cyc++;
      end
      checks++; if (mosi !== 8'hC3 || rises != 8) begin errors++; $display("FAIL dev_mosi got %h over %0d rises want c3 over 8", mosi, rises); end
      checks++; if (sdi_bad) begin errors++; $display("FAIL dev_sdi_stable got change while sck high want none"); end
      checks++; if (rx4 !== 8'h3C) begin errors++; $display("FAIL dev_rx got %h want 3c", rx4); end
      loop4 = 1'b1;
   endtask

   task automatic test_multibyte();
      int nd, settle;
      logic cs_glitch;
      logic [7:0] rx_a, rx_b;
      loop4 = 1'b1; hold4 = 1'b1;
      @(negedge clk); tx4 = 8'h01; start4 = 1'b1;
      @(negedge clk); start4 = 1'b0;
      nd = 0; settle = 0; cs_glitch = 1'b0; rx_a = '0; rx_b = '0;
      for (int c = 0; c < 250 && settle < 4; c++) begin
         start4 = 1'b0;
         if (cs4) cs_glitch = 1'b1;
         if (done4) begin
            nd++;
            if (nd == 1) begin rx_a = rx4; tx4 = 8'h02; start4 = 1'b1; end
            else rx_b = rx4;
         end
         if (nd == 2) settle++;
         @(negedge clk);
      end
      start4 = 1'b0;
      checks++; if (nd != 2) begin errors++; $display("FAIL hold_done_count got %0d want 2", nd); end
      checks++; if (cs_glitch) begin errors++; $display("FAIL hold_cs_low got cs high during held bytes want low"); end
      checks++; if (rx_a !== 8'h01 || rx_b !== 8'h02) begin errors++; $display("FAIL hold_rx got %h %h want 01 02", rx_a, rx_b); end
      checks++; if (cs4 !== 1'b0) begin errors++; $display("FAIL hold_idle_cs got %b want 0", cs4); end
      rel4 = 1'b1;
      @(negedge clk); rel4 = 1'b0;
      checks++; if (cs4 !== 1'b1) begin errors++; $display("FAIL release_cs got %b want 1", cs4); end
      hold4 = 1'b0;
   endtask

   task automatic test_start_held();
      int dones;
      loop4 = 1'b1;
      @(negedge clk); tx4 = 8'h5A; start4 = 1'b1;
      @(negedge clk); start4 = 1'b0;
      dones = 0;
      for (int c = 1; c < 150; c++) begin
         if (c == 10) begin start4 = 1'b1; tx4 = 8'hFF; end
         if (c == 30) start4 = 1'b0;
         if (done4) dones++;
         @(negedge clk);
      end
      start4 = 1'b0;
      checks++; if (dones != 1) begin errors++; $display("FAIL start_held_done_count got %0d want 1", dones); end
      checks++; if (rx4 !== 8'h5A) begin errors++; $display("FAIL start_held_rx got %h want 5a", rx4); end
   endtask

   task automatic test_reset_mid();
      int rises, c;
      logic prev, seen;
      loop4 = 1'b1;
      @(negedge clk); tx4 = 8'hFF; start4 = 1'b1;
      @(negedge clk); start4 = 1'b0;
      rises = 0; prev = sck4; c = 0;
      while (rises < 4 && c < 100) begin
         if (!prev && sck4) rises++;
         prev = sck4;
         if (rises < 4) begin @(negedge clk); c++; end
      end
      checks++; if (rises != 4) begin errors++; $display("FAIL reset_mid_reach got %0d rises want 4", rises); end
      reset_n = 1'b0;
      #1;
      checks++; if ({cs4, sck4, busy4} !== 3'b100) begin errors++; $display("FAIL reset_mid_pins got cs/sck/busy=%b want 100", {cs4, sck4, busy4}); end
      checks++; if (rx4 !== 8'h00) begin errors++; $display("FAIL reset_mid_rx got %h want 00", rx4); end
      @(negedge clk); reset_n = 1'b1;
      @(negedge clk); tx4 = 8'h81; start4 = 1'b1;
      @(negedge clk); start4 = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 120 && !seen; k++) begin
         if (done4) seen = 1'b1;
         else @(negedge clk);
      end
      checks++; if (!seen || rx4 !== 8'h81) begin errors++; $display("FAIL reset_mid_next got done=%b rx=%h want 1 81", seen, rx4); end
   endtask

   task automatic test_stress_div2();
      int cyc, last_rise, done_cyc;
      logic prev, period_bad;
      logic [7:0] b;
      for (int i = 0; i < 256; i++) begin
         b = 8'($urandom_range(0, 255));
         @(negedge clk); tx2 = b; start2 = 1'b1;
         @(negedge clk); start2 = 1'b0; cyc = 1;
         prev = sck2; last_rise = -1; period_bad = 1'b0; done_cyc = 0;
         while (cyc < 60 && done_cyc == 0) begin
            if (!prev && sck2) begin
               if (last_rise >= 0 && cyc - last_rise != 4) period_bad = 1'b1;
               last_rise = cyc;
            end
            if (done2) done_cyc = cyc;
            prev = sck2;
            if (done_cyc == 0) begin @(negedge clk); cyc++; end
         end
         checks++; if (done_cyc != 35) begin errors++; $display("FAIL stress_done_cycle byte %0d got %0d want 35", i, done_cyc); end
         checks++; if (rx2 !== b) begin errors++; $display("FAIL stress_rx byte %0d got %h want %h", i, rx2, b); end
         checks++; if (period_bad) begin errors++; $display("FAIL stress_sck_period byte %0d got period other than 4 want 4", i); end
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      test_loopback();
      test_device();
      test_multibyte();
      test_start_held();
      test_reset_mid();
      test_stress_div2();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_byte_master.md
# spi_byte_master

Hardware SPI master (mode 0, MSB first) that replaces bit-banged SPI on the PicoBlaze output ports. It sits between the processor's port-decode logic, which writes a byte and a start strobe, and the external SPI device pins (`spi_cs`, `spi_clk`, `spi_sdi`, `spi_sdo`). It performs one 8-bit full-duplex transfer per start and returns the received byte with a one-cycle `done` pulse. Chip select can be held low across consecutive bytes for multi-byte transactions.

## Interface
- `CLK_DIV`, default 50: SCK half-period in `clk` cycles (100 MHz gives 1 MHz SCK); legal range 2..255.
- `clk`  input  1: single system clock; all logic on its rising edge.
- `reset_n`  input  1: asynchronous, active-low reset.
- `tx_data`  input  8: byte to transmit; captured on the accepted `start` cycle.
- `start`  input  1: request a transfer; accepted only when `busy`=0.
- `cs_hold`  input  1: captured with `start`. When 1, `spi_cs` stays low after the transfer.
- `release_cs`  input  1: in IDLE, forces `spi_cs` high on the next cycle; ignored while `busy`.
- `busy`  output  1: transfer in progress.
- `done`  output  1: one-cycle pulse at transfer end; `rx_data` is valid from this cycle.
- `rx_data`  output  8: last received byte; holds until the next `done`.
- `spi_cs`  output  1: chip select, active low.
- `spi_clk`  output  1: SCK, idles low (CPOL=0).
- `spi_sdi`  output  1: MOSI, serial data to the device.
- `spi_sdo`  input  1: MISO, serial data from the device.

## Operation
- **States:** IDLE, SETUP, SCK_HI, SCK_LO, FINISH.
- **IDLE:**
  - `start`=1 → capture `tx_data` into the shift register and capture `cs_hold`.
  - Drive `spi_cs`=0 and `spi_sdi`=`tx_data[7]`, then go to SETUP.
- **SETUP:** wait `CLK_DIV` cycles, then `spi_clk`←1 and go to SCK_HI.
- **SCK_HI:**
  - Wait `CLK_DIV` cycles.
  - On the final cycle, sample `spi_sdo` into the shift register LSB (shift left) and set `spi_clk`←0.
  - If 8 bits have been sampled, go to FINISH. Otherwise drive `spi_sdi`←next MSB and go to SCK_LO.
- **SCK_LO:** wait `CLK_DIV` cycles, then `spi_clk`←1 and go to SCK_HI.
- **FINISH:**
  - Wait `CLK_DIV` cycles, then assert `done`, load `rx_data`, and set `busy`←0.
  - `spi_cs`←1 unless the captured `cs_hold`=1.
  - Return to IDLE.
- **Bit counter:** 3 bits, counts samples 0..7. The FINISH transition happens on the sample where the counter equals 7; the counter never wraps in use.
- **Divider counter:** width is the minimum needed to hold `CLK_DIV`−1. It reloads to 0 on every state change.
- **`start` while `busy`=1:** ignored, with no queueing.
- **Back-to-back transfers:** `start` on the `done` cycle is accepted, because `busy`=0 in that cycle.
  - If the previous transfer had `cs_hold`=1, `spi_cs` stays low continuously, with no glitch.
- **`release_cs` and `start` in the same IDLE cycle:** `start` wins, and `spi_cs` stays/goes low.
- **`spi_sdo`:** not synchronised. It is sampled half a period after the rising SCK edge, and `CLK_DIV`≥2 guarantees setup.
- **Reset (asserted at any time, including mid-transfer):** outputs take their reset values immediately.
  - `busy`=0, `done`=0, `rx_data`=8'h00, `spi_cs`=1, `spi_clk`=0, `spi_sdi`=0.
  - State returns to IDLE; the partial byte is discarded.

## Timing
- Cycle 0 is the edge where `start` is sampled high.
- Cycle 1: `busy`=1, `spi_cs`=0, `spi_sdi`=`tx_data[7]`.
- Rising SCK edge k (k=0..7): `spi_clk` goes high at cycle 1+`CLK_DIV`·(2k+1).
- Falling SCK edge k, which is also the sample point: cycle 1+`CLK_DIV`·(2k+2).
  - New `spi_sdi` bit appears in the same cycle.
- `done`=1, `busy`=0 and CS release all occur at cycle 1+17·`CLK_DIV`.
  - `CLK_DIV`=4 gives cycle 69; `CLK_DIV`=50 gives cycle 851.
- SCK duty cycle is exactly 50%; period is 2·`CLK_DIV` cycles.
- `spi_sdi` changes only while `spi_clk`=0 and is stable for `CLK_DIV` cycles before each rising edge.
- All outputs are registered, with no combinational path from any input to any output.

## Structure
- **Package `spi_pkg`:**
  - State encoding enum (IDLE, SETUP, SCK_HI, SCK_LO, FINISH).
  - `SPI_BITS`=8.
  - Reset-value constants for the idle pin levels.
- **Sub-module `spi_half_period_timer`:**
  - Parameter `CLK_DIV`; inputs `clk`, `reset_n`, `clear`.
  - Output `tick`, high on the `CLK_DIV`-th cycle after `clear`.
  - The FSM uses `tick` for all state advances.
- **Top level:** shift register, bit counter, FSM, output registers.

## Test plan
- **Loopback** (`CLK_DIV`=4, `spi_sdo` tied to `spi_sdi`), `tx_data`=8'hA5, `start` for 1 cycle → 8 SCK pulses, `done` at cycle 69, `rx_data`=8'hA5, `spi_cs` high at cycle 69.
- **Device model** returning 8'h3C while the master sends 8'hC3 → MOSI bit sequence 1,1,0,0,0,0,1,1 at the rising edges; `rx_data`=8'h3C.
- **Multi-byte hold:** `cs_hold`=1 for bytes 8'h01 and 8'h02 started on the `done` cycle → `spi_cs` low continuously across both bytes; then `release_cs` → `spi_cs`=1 one cycle later.
- **`start` held high for 20 cycles mid-transfer** → exactly one transfer; `done` pulses once.
- **`reset_n` pulsed low at the 4th rising SCK edge** → immediate `spi_cs`=1, `spi_clk`=0, `busy`=0, `rx_data`=8'h00; the next `start` then completes normally.
- **`CLK_DIV`=2 stress**, 256 random bytes in loopback → every `rx_data` equals its `tx_data`, and the SCK period is 4 cycles throughout.
